// File: rtl/y_alu_ctrl.sv
// Purpose: decode a RISC-V instruction, drive a 32-bit ALU, capture result/zero flag and report branch/illegal.
// Latency: accept at edge k, result valid (out_valid) at edge k+ALU_LAT.
// Backpressure: result held while out_ready=0; in_ready low in EXEC and in DONE unless out_ready=1.
module y_alu_ctrl #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic        alu_ex,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        illegal
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    // Counter preload: number of extra EXEC cycles after the first one.
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        pend_ill;
    logic        pend_beq;
    logic        pend_bne;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic        unused_bits;

    logic        dec_legal;
    logic [2:0]  dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_beq;
    logic        dec_bne;
    logic        accept;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign imm_i       = {{20{instr[31]}}, instr[31:20]};
    assign imm_s       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign unused_bits = ^instr[19:15];

    // Decode the instruction into ALU op, operand b and branch kind; unsupported encodings become a zeroed AND.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_AND;
        dec_b     = '0;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_b = rs2_val;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin dec_op = OP_ADD; dec_legal = 1'b1; end
                        3'b010:  begin dec_op = OP_SLT; dec_legal = 1'b1; end
                        3'b110:  begin dec_op = OP_OR;  dec_legal = 1'b1; end
                        3'b111:  begin dec_op = OP_AND; dec_legal = 1'b1; end
                        default: ;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op    = OP_SUB;
                    dec_legal = 1'b1;
                end
            end
            OPC_I: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000:  begin dec_op = OP_ADD; dec_legal = 1'b1; end
                    3'b010:  begin dec_op = OP_SLT; dec_legal = 1'b1; end
                    3'b110:  begin dec_op = OP_OR;  dec_legal = 1'b1; end
                    3'b111:  begin dec_op = OP_AND; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                dec_b = imm_i;
                if (funct3 == 3'b010) begin
                    dec_op    = OP_ADD;
                    dec_legal = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_b = imm_s;
                if (funct3 == 3'b010) begin
                    dec_op    = OP_ADD;
                    dec_legal = 1'b1;
                end
            end
            OPC_BR: begin
                dec_b  = rs2_val;
                dec_op = OP_SUB;
                case (funct3)
                    3'b000:  begin dec_beq = 1'b1; dec_legal = 1'b1; end
                    3'b001:  begin dec_bne = 1'b1; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec_op  = OP_AND;
            dec_b   = '0;
            dec_beq = 1'b0;
            dec_bne = 1'b0;
        end
    end

    assign dec_a     = dec_legal ? rs1_val : 32'd0;
    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    // Control FSM: load operands on accept, count down the ALU latency, capture, then hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_AND;
            pend_ill     <= 1'b0;
            pend_beq     <= 1'b0;
            pend_bne     <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        result       <= pend_ill ? 32'd0 : alu_z;
                        branch_taken <= (pend_beq && alu_ex) || (pend_bne && !alu_ex);
                        illegal      <= pend_ill;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready && !in_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A new instruction is taken from IDLE, or from DONE in the same cycle the result is consumed.
            if (accept) begin
                alu_a    <= dec_a;
                alu_b    <= dec_b;
                alu_op   <= dec_op;
                pend_ill <= !dec_legal;
                pend_beq <= dec_beq;
                pend_bne <= dec_bne;
                cnt      <= LAT_M1;
                state    <= S_EXEC;
            end
        end
    end

endmodule
